// File: rtl/trellis_table_pkg.sv
// Shared types and sizing helpers for the trellis transition table.
package trellis_table_pkg;

  // Table lifecycle: fill entries, become full, optionally freeze.
  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_FILLING = 2'd1,
    ST_FULL    = 2'd2,
    ST_LOCKED  = 2'd3
  } table_state_t;

  // Width of one packed row of next-state fields (B*S).
  function automatic int row_ns_width(input int k, input int s);
    return (1 << k) * s;
  endfunction

  // Width of one packed row of output fields (B*N).
  function automatic int row_out_width(input int k, input int n);
    return (1 << k) * n;
  endfunction

  // Number of entries in the whole table (R*B).
  function automatic int entry_count(input int k, input int m);
    return (1 << (m - k)) * (1 << k);
  endfunction

endpackage

// File: rtl/trellis_row_store.sv
// Row storage for the trellis table: per-entry next state, output and
// valid bit, one write port and a registered one-row read port.
// A read and a write (or clear) in the same cycle return the old contents,
// because the read register samples the arrays before they update.
module trellis_row_store
  import trellis_table_pkg::*;
#(
  parameter int K = 1,
  parameter int S = 2,
  parameter int N = 2,
  localparam int B   = 1 << K,
  localparam int R   = 1 << S,
  localparam int NSW = row_ns_width(K, S),
  localparam int OW  = row_out_width(K, N)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clear,
  input  logic           we,
  input  logic [S-1:0]   wr_row,
  input  logic [K-1:0]   wr_branch,
  input  logic [S-1:0]   wr_next,
  input  logic [N-1:0]   wr_out,
  output logic           wr_entry_valid,
  input  logic           rd_req,
  input  logic [S-1:0]   rd_row,
  output logic           rd_valid,
  output logic [NSW-1:0] rd_next_states,
  output logic [OW-1:0]  rd_outputs,
  output logic           rd_miss
);

  logic [S-1:0] ns_mem  [R][B];
  logic [N-1:0] out_mem [R][B];
  logic [B-1:0] vld_mem [R];

  logic [NSW-1:0] ns_pack;
  logic [OW-1:0]  out_pack;

  assign wr_entry_valid = vld_mem[wr_row][wr_branch];

  // Pack the addressed row, branch 0 in the most significant field.
  always_comb begin
    ns_pack  = '0;
    out_pack = '0;
    for (int b = 0; b < B; b++) begin
      ns_pack[(B-1-b)*S +: S]  = ns_mem[rd_row][b];
      out_pack[(B-1-b)*N +: N] = out_mem[rd_row][b];
    end
  end

  // Entry arrays: wiped by reset or clear, otherwise one entry per write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < R; r++) begin
        vld_mem[r] <= '0;
        for (int b = 0; b < B; b++) begin
          ns_mem[r][b]  <= '0;
          out_mem[r][b] <= '0;
        end
      end
    end else if (clear) begin
      for (int r = 0; r < R; r++) begin
        vld_mem[r] <= '0;
        for (int b = 0; b < B; b++) begin
          ns_mem[r][b]  <= '0;
          out_mem[r][b] <= '0;
        end
      end
    end else if (we) begin
      ns_mem[wr_row][wr_branch]  <= wr_next;
      out_mem[wr_row][wr_branch] <= wr_out;
      vld_mem[wr_row][wr_branch] <= 1'b1;
    end
  end

  // Registered read port: one-cycle latency, valid only after a request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_valid       <= 1'b0;
      rd_next_states <= '0;
      rd_outputs     <= '0;
      rd_miss        <= 1'b0;
    end else begin
      rd_valid <= rd_req;
      if (rd_req) begin
        rd_next_states <= ns_pack;
        rd_outputs     <= out_pack;
        rd_miss        <= ~(&vld_mem[rd_row]);
      end
    end
  end

endmodule

// File: rtl/trellis_table.sv
// Trellis transition table: loadable next-state/output entries per
// (state, input) pair, with fill tracking, freeze and a one-cycle read.
// Optional build macro TRELLIS_OVERWRITE_PROTECT_EN: writes to an entry
// that already holds data are dropped and flagged on load_err.
//
// Handshake: a write is accepted in a cycle where load_valid and load_ready
// are both high at the rising clk edge; load_ready depends combinationally
// on clear and the current state only, never on load_valid.
module trellis_table
  import trellis_table_pkg::*;
#(
  parameter int K = 1,
  parameter int M = 3,
  parameter int N = 2,
  localparam int S   = M - K,
  localparam int NSW = row_ns_width(K, S),
  localparam int OW  = row_out_width(K, N)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clear,
  input  logic           load_valid,
  output logic           load_ready,
  input  logic [S-1:0]   state_address,
  input  logic [K-1:0]   input_address,
  input  logic [S-1:0]   next_state_data,
  input  logic [N-1:0]   output_data,
  input  logic           lock,
  input  logic           rd_req,
  input  logic [S-1:0]   rd_state,
  output logic           rd_valid,
  output logic [NSW-1:0] rd_next_states,
  output logic [OW-1:0]  rd_outputs,
  output logic           rd_miss,
  output logic           table_full,
  output logic           locked,
  output logic           load_err,
  output logic [M:0]     entries_loaded,
  output table_state_t   dbg_state
);

  localparam logic [M:0] TOTAL_CNT = (M+1)'(entry_count(K, M));

  table_state_t state;
  logic         accept;
  logic         entry_valid;
  logic         do_write;
  logic         ow_err;
  logic         lock_err;
  logic         count_inc;
  logic [M:0]   count_next;

  assign load_ready = (state != ST_LOCKED) && !clear;
  assign accept     = load_valid && load_ready;
  assign lock_err   = load_valid && (state == ST_LOCKED) && !clear;

`ifdef TRELLIS_OVERWRITE_PROTECT_EN
  assign do_write = accept && !entry_valid;
  assign ow_err   = accept && entry_valid;
`else
  assign do_write = accept;
  assign ow_err   = 1'b0;
`endif

  // Only a write into a previously empty entry grows the count.
  assign count_inc  = do_write && !entry_valid;
  assign count_next = entries_loaded + 1'b1;

  assign table_full = (state == ST_FULL) || (state == ST_LOCKED);
  assign locked     = (state == ST_LOCKED);
  assign dbg_state  = state;

  // Lifecycle FSM with the entry counter and the registered error pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ST_EMPTY;
      entries_loaded <= '0;
      load_err       <= 1'b0;
    end else if (clear) begin
      state          <= ST_EMPTY;
      entries_loaded <= '0;
      load_err       <= 1'b0;
    end else begin
      load_err <= lock_err || ow_err;
      if (count_inc) begin
        entries_loaded <= count_next;
      end
      case (state)
        ST_EMPTY, ST_FILLING: begin
          if (do_write) begin
            state <= (count_inc && count_next == TOTAL_CNT) ? ST_FULL : ST_FILLING;
          end
        end
        ST_FULL: begin
          if (lock) begin
            state <= ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          state <= ST_LOCKED;
        end
        default: begin
          state <= ST_EMPTY;
        end
      endcase
    end
  end

  trellis_row_store #(
    .K (K),
    .S (S),
    .N (N)
  ) u_store (
    .clk            (clk),
    .reset          (reset),
    .clear          (clear),
    .we             (do_write),
    .wr_row         (state_address),
    .wr_branch      (input_address),
    .wr_next        (next_state_data),
    .wr_out         (output_data),
    .wr_entry_valid (entry_valid),
    .rd_req         (rd_req),
    .rd_row         (rd_state),
    .rd_valid       (rd_valid),
    .rd_next_states (rd_next_states),
    .rd_outputs     (rd_outputs),
    .rd_miss        (rd_miss)
  );

endmodule

// File: tb/tb_trellis_table.sv
// Bench for trellis_table with K=1, M=3, N=2 (4 rows x 2 branches).
module tb_trellis_table;
  import trellis_table_pkg::*;

  localparam int K = 1;
  localparam int M = 3;
  localparam int N = 2;
  localparam int S = 2;
  localparam int B = 2;
  localparam int R = 4;

`ifdef TRELLIS_OVERWRITE_PROTECT_EN
  localparam bit PROTECT = 1'b1;
`else
  localparam bit PROTECT = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         clear;
  logic         load_valid;
  logic         load_ready;
  logic [S-1:0] state_address;
  logic [K-1:0] input_address;
  logic [S-1:0] next_state_data;
  logic [N-1:0] output_data;
  logic         lock;
  logic         rd_req;
  logic [S-1:0] rd_state;
  logic         rd_valid;
  logic [3:0]   rd_next_states;
  logic [3:0]   rd_outputs;
  logic         rd_miss;
  logic         table_full;
  logic         locked;
  logic         load_err;
  logic [M:0]   entries_loaded;
  table_state_t dbg_state;

  int total = 0;
  int bad   = 0;

  // Reference model of the table contents and lifecycle.
  logic [S-1:0] m_ns  [R][B];
  logic [N-1:0] m_out [R][B];
  logic         m_vld [R][B];
  int           m_count;
  table_state_t m_state;
  logic         m_err;

  // Expected read responses: {next_states[3:0], outputs[3:0], miss}.
  logic [8:0] exp_q[$];

  trellis_table #(.K(K), .M(M), .N(N)) dut (
    .clk             (clk),
    .reset           (reset),
    .clear           (clear),
    .load_valid      (load_valid),
    .load_ready      (load_ready),
    .state_address   (state_address),
    .input_address   (input_address),
    .next_state_data (next_state_data),
    .output_data     (output_data),
    .lock            (lock),
    .rd_req          (rd_req),
    .rd_state        (rd_state),
    .rd_valid        (rd_valid),
    .rd_next_states  (rd_next_states),
    .rd_outputs      (rd_outputs),
    .rd_miss         (rd_miss),
    .table_full      (table_full),
    .locked          (locked),
    .load_err        (load_err),
    .entries_loaded  (entries_loaded),
    .dbg_state       (dbg_state)
  );

  // Clock and reset block
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_wipe();
    for (int r = 0; r < R; r++) begin
      for (int b = 0; b < B; b++) begin
        m_ns[r][b]  = '0;
        m_out[r][b] = '0;
        m_vld[r][b] = 1'b0;
      end
    end
    m_count = 0;
    m_state = ST_EMPTY;
    m_err   = 1'b0;
  endtask

  function automatic logic [8:0] model_row(input int r);
    logic [3:0] ns;
    logic [3:0] o;
    logic       miss;
    ns   = {m_ns[r][0], m_ns[r][1]};
    o    = {m_out[r][0], m_out[r][1]};
    miss = !(m_vld[r][0] && m_vld[r][1]);
    return {ns, o, miss};
  endfunction

  task automatic idle_inputs();
    clear           = 1'b0;
    load_valid      = 1'b0;
    state_address   = '0;
    input_address   = '0;
    next_state_data = '0;
    output_data     = '0;
    lock            = 1'b0;
    rd_req          = 1'b0;
    rd_state        = '0;
  endtask

  task automatic check_status();
    chk("entries_loaded", entries_loaded, m_count);
    chk("table_full", table_full, (m_state == ST_FULL) || (m_state == ST_LOCKED));
    chk("locked", locked, m_state == ST_LOCKED);
    chk("load_err", load_err, m_err);
    chk("state", dbg_state, m_state);
  endtask

  // Driver: one clock cycle of stimulus. hand >= 0 gives a hand-computed
  // read expectation instead of the model's row.
  task automatic cyc(input logic lv, input int sr, input int br, input int nd, input int od,
                     input logic rq, input int rr, input logic clr, input logic lk,
                     input int hand);
    table_state_t prev;
    load_valid      = lv;
    state_address   = sr[S-1:0];
    input_address   = br[K-1:0];
    next_state_data = nd[S-1:0];
    output_data     = od[N-1:0];
    rd_req          = rq;
    rd_state        = rr[S-1:0];
    clear           = clr;
    lock            = lk;
    #1;
    chk("load_ready", load_ready, (m_state != ST_LOCKED) && !clr);
    if (rq) begin
      if (hand >= 0) exp_q.push_back(hand[8:0]);
      else exp_q.push_back(model_row(rr));
    end
    prev  = m_state;
    m_err = 1'b0;
    if (clr) begin
      model_wipe();
    end else begin
      if (lv) begin
        if (prev == ST_LOCKED) begin
          m_err = 1'b1;
        end else if (PROTECT && m_vld[sr][br]) begin
          m_err = 1'b1;
        end else begin
          if (!m_vld[sr][br]) m_count++;
          m_ns[sr][br]  = nd[S-1:0];
          m_out[sr][br] = od[N-1:0];
          m_vld[sr][br] = 1'b1;
          if (prev == ST_EMPTY || prev == ST_FILLING)
            m_state = (m_count == R * B) ? ST_FULL : ST_FILLING;
        end
      end
      if (prev == ST_FULL && lk) m_state = ST_LOCKED;
    end
    @(posedge clk);
    #1;
    idle_inputs();
    check_status();
  endtask

  task automatic wr(input int r, input int b, input int nd, input int od);
    cyc(1'b1, r, b, nd, od, 1'b0, 0, 1'b0, 1'b0, -1);
  endtask

  task automatic rd(input int r, input int hand);
    cyc(1'b0, 0, 0, 0, 0, 1'b1, r, 1'b0, 1'b0, hand);
  endtask

  task automatic idle();
    cyc(1'b0, 0, 0, 0, 0, 1'b0, 0, 1'b0, 1'b0, -1);
  endtask

  // Scoreboard monitor: pop and compare whenever a read response appears.
  always @(negedge clk) begin
    if (rd_valid) begin
      if (exp_q.size() == 0) begin
        chk("rd_unexpected", {rd_next_states, rd_outputs, rd_miss}, 32'hFFFF_FFFF);
      end else begin
        chk("rd_row", {rd_next_states, rd_outputs, rd_miss}, exp_q.pop_front());
      end
    end
  end

  initial begin
    idle_inputs();
    model_wipe();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check_status();
    chk("rst_rd_valid", rd_valid, 1'b0);
    chk("rst_rd_data", {rd_next_states, rd_outputs, rd_miss}, 9'd0);

    // Single entry then read of the partial row: miss, FILLING, count 1.
    wr(1, 0, 2, 1);
    rd(1, 9'b1000_0100_1);

    // Fill every entry with next=(2*row+b)%4, out=row^b.
    for (int r = 0; r < R; r++) begin
      for (int b = 0; b < B; b++) begin
        wr(r, b, (2 * r + b) % 4, r ^ b);
      end
    end
    rd(2, 9'b0001_1011_0);
    rd(0, -1);

    // Rewrite a valid entry: replaced, or retained with an error pulse.
    wr(0, 0, 3, 3);
    idle();
    rd(0, -1);

    // Freeze, then try to write while frozen.
    cyc(1'b0, 0, 0, 0, 0, 1'b0, 0, 1'b0, 1'b1, -1);
    wr(0, 1, 2, 2);
    idle();
    rd(0, -1);
    idle();

    // Clear with a simultaneous write and read of row 2.
    cyc(1'b1, 2, 0, 3, 3, 1'b1, 2, 1'b1, 1'b0, 9'b0001_1011_0);
    idle();
    rd(2, 9'b0000_0000_1);

    // Write and read row 3 in the same cycle, then read again.
    cyc(1'b1, 3, 0, 2, 2, 1'b1, 3, 1'b0, 1'b0, 9'b0000_0000_1);
    rd(3, 9'b1000_1000_1);

    // Asynchronous reset in the middle of a fill with a write pending.
    wr(0, 0, 1, 1);
    wr(1, 1, 3, 2);
    load_valid      = 1'b1;
    state_address   = 2'd2;
    input_address   = 1'b0;
    next_state_data = 2'd3;
    output_data     = 2'd3;
    #2;
    reset = 1'b1;
    #1;
    model_wipe();
    check_status();
    chk("arst_rd_valid", rd_valid, 1'b0);
    chk("arst_rd_data", {rd_next_states, rd_outputs, rd_miss}, 9'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle_inputs();
    check_status();
    rd(2, 9'b0000_0000_1);
    rd(0, 9'b0000_0000_1);

    repeat (3) idle();
    chk("reads_outstanding", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
